// File: rtl/cmp_pkg.sv
// cmp_pkg: shared channel state type and select-width helper for cmp_match_unit.
package cmp_pkg;
    typedef enum logic {DISARMED, ARMED} chan_state_t;
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cmp_channel.sv
// cmp_channel: one reference/mask/state register set with a masked equality compare.
module cmp_channel
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_ref,
    input  logic [WIDTH-1:0] wr_mask,
    input  logic             cmp_valid,
    input  logic [WIDTH-1:0] cmp_data,
    output logic             hit
);
    chan_state_t      state;
    logic [WIDTH-1:0] ref_word;
    logic [WIDTH-1:0] mask_word;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DISARMED;
            ref_word  <= '0;
            mask_word <= '0;
        end else if (wr_en) begin
            state     <= (|wr_mask) ? ARMED : DISARMED;
            ref_word  <= wr_ref;
            mask_word <= wr_mask;
        end
    end
    // hit is combinational on the current registers, so a same-cycle write sees the old values
    assign hit = (state == ARMED) && cmp_valid && ~|((cmp_data ^ ref_word) & mask_word);
endmodule

// File: rtl/cmp_match_unit.sv
// cmp_match_unit: multi-channel masked compare unit with registered match, 74x521-style any_match_n and sticky hits.
// Define CMP_HIT_COUNTER_EN to add the saturating hit_count output.
module cmp_match_unit
    import cmp_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [sel_width(CHANNELS)-1:0] wr_sel,
    input  logic [WIDTH-1:0]               wr_ref,
    input  logic [WIDTH-1:0]               wr_mask,
    input  logic                           cmp_valid,
    input  logic [WIDTH-1:0]               cmp_data,
    input  logic                           clr_sticky,
    output logic [CHANNELS-1:0]            match,
    output logic                           any_match_n,
`ifdef CMP_HIT_COUNTER_EN
    output logic [CHANNELS-1:0]            sticky,
    output logic [CNT_WIDTH-1:0]           hit_count
`else
    output logic [CHANNELS-1:0]            sticky
`endif
);
    localparam int SW = sel_width(CHANNELS);
    logic [CHANNELS-1:0] hit;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        cmp_channel #(.WIDTH(WIDTH)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (wr_en && (wr_sel == SW'(i))),
            .wr_ref    (wr_ref),
            .wr_mask   (wr_mask),
            .cmp_valid (cmp_valid),
            .cmp_data  (cmp_data),
            .hit       (hit[i])
        );
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            match       <= '0;
            any_match_n <= 1'b1;
            sticky      <= '0;
        end else begin
            match       <= hit;
            any_match_n <= ~|hit;
            sticky      <= (sticky & {CHANNELS{~clr_sticky}}) | hit;
        end
    end
`ifdef CMP_HIT_COUNTER_EN
    // a hit in the clearing cycle restarts the count at one
    always_ff @(posedge clk) begin
        if (rst)
            hit_count <= '0;
        else if (|hit)
            hit_count <= clr_sticky ? CNT_WIDTH'(1) : (&hit_count ? hit_count : hit_count + 1'b1);
        else if (clr_sticky)
            hit_count <= '0;
    end
`endif
endmodule

// File: tb/tb_cmp_match_unit.sv
// tb_cmp_match_unit: scoreboard bench for cmp_match_unit (counter tests only with CMP_HIT_COUNTER_EN).
module tb_cmp_match_unit;
    localparam int W  = 8;
    localparam int CH = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_sel = '0;
    logic [W-1:0]  wr_ref = '0;
    logic [W-1:0]  wr_mask = '0;
    logic          cmp_valid = 1'b0;
    logic [W-1:0]  cmp_data = '0;
    logic          clr_sticky = 1'b0;
    logic [CH-1:0] match;
    logic          any_match_n;
    logic [CH-1:0] sticky;
`ifdef CMP_HIT_COUNTER_EN
    logic [CW-1:0] hit_count;
`endif

    cmp_match_unit #(.WIDTH(W), .CHANNELS(CH), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_ref      (wr_ref),
        .wr_mask     (wr_mask),
        .cmp_valid   (cmp_valid),
        .cmp_data    (cmp_data),
        .clr_sticky  (clr_sticky),
        .match       (match),
        .any_match_n (any_match_n),
`ifdef CMP_HIT_COUNTER_EN
        .sticky      (sticky),
        .hit_count   (hit_count)
`else
        .sticky      (sticky)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [W-1:0]  mref [CH];
    logic [W-1:0]  mmask [CH];
    logic          marm [CH];
    logic [CH-1:0] msticky = '0;
    logic [CW-1:0] mcnt = '0;
    logic [8:0]    sb [$];
    logic [8:0]    exp;

    // reference model: evaluate pre-edge state, push expectation, then advance the clock
    task automatic cycle();
        logic [CH-1:0] h;
        for (int c = 0; c < CH; c++)
            h[c] = marm[c] && cmp_valid && (((cmp_data ^ mref[c]) & mmask[c]) == '0);
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                marm[c] = 1'b0; mref[c] = '0; mmask[c] = '0;
            end
            msticky = '0;
            mcnt = '0;
            sb.push_back({4'b0000, 1'b1, 4'b0000});
        end else begin
            msticky = (msticky & {CH{~clr_sticky}}) | h;
            if (|h) mcnt = clr_sticky ? 4'd1 : ((mcnt == 4'hF) ? mcnt : mcnt + 4'd1);
            else if (clr_sticky) mcnt = '0;
            if (wr_en) begin
                mref[wr_sel] = wr_ref; mmask[wr_sel] = wr_mask; marm[wr_sel] = |wr_mask;
            end
            sb.push_back({h, ~|h, msticky});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; wr_en = 0; cmp_valid = 0; clr_sticky = 0;
    endtask

    task automatic load(input logic [1:0] s, input logic [W-1:0] r, input logic [W-1:0] m);
        idle();
        wr_en = 1; wr_sel = s; wr_ref = r; wr_mask = m;
        cycle();
        exp = sb.pop_front();
        checks++;
        if ({match, any_match_n, sticky} !== exp) begin
            failures++;
            $display("FAIL load_ch%0d got=%b exp=%b", s, {match, any_match_n, sticky}, exp);
        end
        wr_en = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        cycle();
        exp = sb.pop_front();
        checks++;
        if ({match, any_match_n, sticky} !== 9'b0000_1_0000) begin
            failures++;
            $display("FAIL reset_values got=%b exp=%b", {match, any_match_n, sticky}, 9'b0000_1_0000);
        end
        checks++;
        if ({match, any_match_n, sticky} !== exp) begin
            failures++;
            $display("FAIL reset_sb got=%b exp=%b", {match, any_match_n, sticky}, exp);
        end
        rst = 0;
    endtask

    task automatic test_disarmed();
        idle();
        cmp_valid = 1; cmp_data = 8'h00;
        cycle();
        exp = sb.pop_front();
        checks++;
        if (match !== 4'b0000 || any_match_n !== 1'b1 || {match, any_match_n, sticky} !== exp) begin
            failures++;
            $display("FAIL disarmed got=%b exp=%b", {match, any_match_n, sticky}, exp);
        end
    endtask

    task automatic test_basic();
        load(2'd0, 8'hA5, 8'hFF);
        cmp_valid = 1; cmp_data = 8'hA5;
        cycle();
        exp = sb.pop_front();
        checks++;
        if (match !== 4'b0001 || any_match_n !== 1'b0 || sticky[0] !== 1'b1 || {match, any_match_n, sticky} !== exp) begin
            failures++;
            $display("FAIL basic_hit got=%b exp=%b", {match, any_match_n, sticky}, exp);
        end
        idle();
        cycle();
        exp = sb.pop_front();
        checks++;
        if (match !== 4'b0000 || any_match_n !== 1'b1 || sticky !== 4'b0001 || {match, any_match_n, sticky} !== exp) begin
            failures++;
            $display("FAIL valid_low got=%b exp=%b", {match, any_match_n, sticky}, exp);
        end
    endtask

    task automatic test_mask();
        load(2'd1, 8'h30, 8'hF0);
        cmp_valid = 1; cmp_data = 8'h3C;
        cycle();
        exp = sb.pop_front();
        checks++;
        if (match !== 4'b0010 || {match, any_match_n, sticky} !== exp) begin
            failures++;
            $display("FAIL mask_hit got=%b exp=%b", {match, any_match_n, sticky}, exp);
        end
        cmp_data = 8'h4C;
        cycle();
        exp = sb.pop_front();
        checks++;
        if (match !== 4'b0000 || any_match_n !== 1'b1 || {match, any_match_n, sticky} !== exp) begin
            failures++;
            $display("FAIL mask_miss got=%b exp=%b", {match, any_match_n, sticky}, exp);
        end
    endtask

    task automatic test_same_cycle();
        idle();
        wr_en = 1; wr_sel = 2'd0; wr_ref = 8'h11; wr_mask = 8'hFF;
        cmp_valid = 1; cmp_data = 8'hA5;
        cycle();
        exp = sb.pop_front();
        checks++;
        if (match[0] !== 1'b1 || {match, any_match_n, sticky} !== exp) begin
            failures++;
            $display("FAIL same_cycle_old got=%b exp=%b", {match, any_match_n, sticky}, exp);
        end
        wr_en = 0;
        cycle();
        exp = sb.pop_front();
        checks++;
        if (match[0] !== 1'b0 || {match, any_match_n, sticky} !== exp) begin
            failures++;
            $display("FAIL same_cycle_new got=%b exp=%b", {match, any_match_n, sticky}, exp);
        end
    endtask

    task automatic test_sticky();
        load(2'd2, 8'h77, 8'hFF);
        cmp_valid = 1; cmp_data = 8'h77; clr_sticky = 1;
        cycle();
        exp = sb.pop_front();
        checks++;
        if (sticky !== 4'b0100 || {match, any_match_n, sticky} !== exp) begin
            failures++;
            $display("FAIL sticky_set_wins got=%b exp=%b", {match, any_match_n, sticky}, exp);
        end
        cmp_valid = 0;
        cycle();
        exp = sb.pop_front();
        checks++;
        if (sticky !== 4'b0000 || {match, any_match_n, sticky} !== exp) begin
            failures++;
            $display("FAIL sticky_clear got=%b exp=%b", {match, any_match_n, sticky}, exp);
        end
    endtask

    task automatic test_disarm();
        load(2'd1, 8'h00, 8'h00);
        cmp_valid = 1; cmp_data = 8'h00;
        cycle();
        exp = sb.pop_front();
        checks++;
        if (match[1] !== 1'b0 || {match, any_match_n, sticky} !== exp) begin
            failures++;
            $display("FAIL disarm got=%b exp=%b", {match, any_match_n, sticky}, exp);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 60; n++) begin
            int k;
            k = $urandom_range(0, 3);
            wr_en = ($urandom_range(0, 3) == 0);
            wr_sel = 2'($urandom_range(0, 3));
            wr_ref = 8'($urandom);
            wr_mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            cmp_valid = ($urandom_range(0, 4) != 0);
            cmp_data = ($urandom_range(0, 1) == 1) ? (mref[k] ^ (8'($urandom) & ~mmask[k])) : 8'($urandom);
            clr_sticky = ($urandom_range(0, 7) == 0);
            cycle();
            exp = sb.pop_front();
            checks++;
            if ({match, any_match_n, sticky} !== exp) begin
                failures++;
                $display("FAIL b2b_%0d got=%b exp=%b", n, {match, any_match_n, sticky}, exp);
            end
`ifdef CMP_HIT_COUNTER_EN
            checks++;
            if (hit_count !== mcnt) begin
                failures++;
                $display("FAIL b2b_cnt_%0d got=%h exp=%h", n, hit_count, mcnt);
            end
`endif
        end
        idle();
    endtask

`ifdef CMP_HIT_COUNTER_EN
    task automatic test_counter();
        load(2'd3, 8'h5A, 8'hFF);
        cmp_valid = 1; cmp_data = 8'h5A; clr_sticky = 1;
        cycle();
        void'(sb.pop_front());
        checks++;
        if (hit_count !== 4'd1) begin
            failures++;
            $display("FAIL cnt_clr_hit got=%h exp=1", hit_count);
        end
        clr_sticky = 0;
        for (int n = 0; n < 20; n++) begin
            cycle();
            void'(sb.pop_front());
        end
        checks++;
        if (hit_count !== 4'hF || hit_count !== mcnt) begin
            failures++;
            $display("FAIL cnt_saturate got=%h exp=f", hit_count);
        end
        cmp_valid = 0; clr_sticky = 1;
        cycle();
        void'(sb.pop_front());
        checks++;
        if (hit_count !== 4'd0) begin
            failures++;
            $display("FAIL cnt_clear got=%h exp=0", hit_count);
        end
        idle();
    endtask
`endif

    task automatic test_reset_mid();
        load(2'd0, 8'hA5, 8'hFF);
        cmp_valid = 1; cmp_data = 8'hA5;
        cycle();
        void'(sb.pop_front());
        rst = 1; wr_en = 1; wr_sel = 2'd1; wr_ref = 8'h12; wr_mask = 8'hFF; clr_sticky = 1;
        cycle();
        exp = sb.pop_front();
        checks++;
        if ({match, any_match_n, sticky} !== 9'b0000_1_0000 || {match, any_match_n, sticky} !== exp) begin
            failures++;
            $display("FAIL reset_mid got=%b exp=%b", {match, any_match_n, sticky}, exp);
        end
`ifdef CMP_HIT_COUNTER_EN
        checks++;
        if (hit_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid_cnt got=%h exp=0", hit_count);
        end
`endif
        idle();
        cmp_valid = 1; cmp_data = 8'hA5;
        cycle();
        exp = sb.pop_front();
        checks++;
        if (match !== 4'b0000 || {match, any_match_n, sticky} !== exp) begin
            failures++;
            $display("FAIL reset_disarms got=%b exp=%b", {match, any_match_n, sticky}, exp);
        end
        idle();
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            marm[c] = 1'b0; mref[c] = '0; mmask[c] = '0;
        end
        test_reset();
        test_disarmed();
        test_basic();
        test_mask();
        test_same_cycle();
        test_sticky();
        test_disarm();
        test_back_to_back();
`ifdef CMP_HIT_COUNTER_EN
        test_counter();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
